demux_slot_scheduler: RTL and testbench

Round-robin slot scheduler for the 1-to-8 channel demultiplexer in the time-domain RF path. It arbitrates among eight channel requests and grants one channel per time slot of programmable dwell length. It drives the demultiplexer select and the gated serial data, with optional guard cycles so that the select never changes while data is live. It sits directly upstream of the demultiplexer and is the only source of its select and data inputs.

---
 rtl/demux_slot_scheduler_pkg.sv | 25 ++
 rtl/demux_slot_scheduler_if.sv | 30 +++
 rtl/demux_slot_scheduler_arb.sv | 30 +++
 rtl/demux_slot_scheduler.sv | 104 ++++++++++
 tb/tb_demux_slot_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_slot_scheduler_pkg.sv
// Shared types and helpers for the demux slot scheduler: channel count,
// select width, FSM state encoding and one-hot to select conversion.
package demux_sched_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    SETTLE = 2'd2,
    DWELL  = 2'd3
  } state_t;

  // Encode a one-hot grant vector into the demultiplexer select index.
  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [NUM_CH-1:0] oh);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) sel = sel | SEL_W'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/demux_slot_scheduler_if.sv
// Bundle of scheduler control/data signals between the request side
// (master) and the scheduler (slave).
interface demux_slot_scheduler_if
  import demux_sched_pkg::*;
#(
  parameter int DWELL_W = 8
);

  logic               en_i;
  logic [NUM_CH-1:0]  req_i;
  logic [DWELL_W-1:0] dwell_i;
  logic               data_i;
  logic [SEL_W-1:0]   sel_o;
  logic               data_o;
  logic               valid_o;
  logic [NUM_CH-1:0]  grant_o;
  logic               busy_o;
  logic               slot_done_o;

  modport master (
    output en_i, req_i, dwell_i, data_i,
    input  sel_o, data_o, valid_o, grant_o, busy_o, slot_done_o
  );

  modport slave (
    input  en_i, req_i, dwell_i, data_i,
    output sel_o, data_o, valid_o, grant_o, busy_o, slot_done_o
  );

endinterface

// File: rtl/demux_slot_scheduler_arb.sv
// Combinational 8-way round-robin arbiter: grants the first requesting
// channel at or after ptr, wrapping from 7 back to 0.
module rr_arbiter_8
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic              any
);

  // Scan channels starting at ptr and pick the first active request.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = ptr + SEL_W'(off);
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/demux_slot_scheduler.sv
// Round-robin slot scheduler driving the 1-to-8 demultiplexer select and
// gated serial data. One channel owns each slot; optional guard cycles keep
// the select stable before data is enabled.
module demux_slot_scheduler
  import demux_sched_pkg::*;
#(
  parameter int GUARD_CYCLES = 1,
  parameter int DWELL_W      = 8
)(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  demux_slot_scheduler_if.slave bus
);

  // Guard counter is sized for the largest preload; width is at least 1 so
  // the zero-guard build still elaborates.
  localparam int GUARD_W        = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int GUARD_LOAD_INT = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_LOAD_INT);
  localparam state_t ARB_NEXT   = (GUARD_CYCLES == 0) ? DWELL : SETTLE;

  state_t             state;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_CH-1:0]  grant_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [GUARD_W-1:0] guard_cnt;

  logic [NUM_CH-1:0]  arb_gnt;
  logic               arb_any;
  logic [DWELL_W-1:0] dwell_load;
  logic               slot_end;
  logic               rearm;

  rr_arbiter_8 u_arb (
    .req (bus.req_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // A zero dwell is treated as a one-cycle slot.
  assign dwell_load = (bus.dwell_i == '0) ? '0 : bus.dwell_i - 1'b1;
  assign slot_end   = (state == DWELL) && (dwell_cnt == '0);
  assign rearm      = bus.en_i && (|bus.req_i);

  // Slot FSM, counters, round-robin pointer and registered select/grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      dwell_cnt <= '0;
      guard_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rearm) state <= ARB;
        end
        ARB: begin
          // Request may have vanished since IDLE/DWELL sampled it; in that
          // case leave select, grant and pointer untouched.
          if (arb_any) begin
            sel_q     <= onehot_to_sel(arb_gnt);
            grant_q   <= arb_gnt;
            dwell_cnt <= dwell_load;
            guard_cnt <= GUARD_LOAD;
            state     <= ARB_NEXT;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (guard_cnt == '0) state <= DWELL;
          else                 guard_cnt <= guard_cnt - 1'b1;
        end
        DWELL: begin
          if (dwell_cnt == '0) begin
            rr_ptr <= sel_q + 1'b1;
            if (rearm) begin
              state <= ARB;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from state so an async reset clears them at once.
  assign bus.sel_o       = sel_q;
  assign bus.grant_o     = grant_q;
  assign bus.valid_o     = (state == DWELL);
  assign bus.busy_o      = (state != IDLE);
  assign bus.slot_done_o = slot_end;
  assign bus.data_o      = bus.data_i & bus.valid_o;

endmodule

// File: tb/tb_demux_slot_scheduler.sv
// Testbench for demux_slot_scheduler: directed slot scenarios with a
// scoreboard of expected slots checked by an independent monitor.
module tb_demux_slot_scheduler;
  import demux_sched_pkg::*;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] grant;
    int         len;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t q[$];

  demux_slot_scheduler_if #(.DWELL_W(8)) ifa ();
  demux_slot_scheduler_if #(.DWELL_W(8)) ifb ();

  demux_slot_scheduler #(.GUARD_CYCLES(1), .DWELL_W(8)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifa.slave)
  );

  demux_slot_scheduler #(.GUARD_CYCLES(0), .DWELL_W(8)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input int len);
    exp_t e;
    e.sel   = 3'(ch);
    e.grant = 8'(1 << ch);
    e.len   = len;
    q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.slot_done_o && n < 300);
    if (!ifa.slot_done_o) begin
      errors++;
      checks++;
      $display("FAIL %s: slot_done timeout, got 0 expected 1", name);
    end
  endtask

  task automatic wait_sig(input string name, input bit want_valid);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((want_valid ? ifa.valid_o : ifa.busy_o) !== 1'b1) && n < 300);
    if ((want_valid ? ifa.valid_o : ifa.busy_o) !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL %s: wait timeout, got 0 expected 1", name);
    end
  endtask

  // Serial data source for both instances.
  initial begin
    ifa.data_i = 1'b0;
    ifb.data_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ifa.data_i = 1'($urandom_range(0, 1));
      ifb.data_i = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: data gating, select stability, and per-slot scoreboard compare.
  initial begin
    int         vcnt;
    logic [2:0] sel_ref;
    exp_t       e;
    vcnt    = 0;
    sel_ref = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vcnt = 0;
      end else begin
        chk("data_gate", 32'(ifa.data_o), 32'(ifa.valid_o ? ifa.data_i : 1'b0));
        if (ifa.valid_o) begin
          if (vcnt == 0) sel_ref = ifa.sel_o;
          else           chk("sel_stable", 32'(ifa.sel_o), 32'(sel_ref));
          vcnt++;
        end
        if (ifa.slot_done_o) begin
          if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_slot: got sel %0d expected no slot", ifa.sel_o);
          end else begin
            e = q.pop_front();
            chk("slot_sel",   32'(ifa.sel_o),   32'(e.sel));
            chk("slot_grant", 32'(ifa.grant_o), 32'(e.grant));
            chk("slot_len",   32'(vcnt),        32'(e.len));
          end
          vcnt = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    ifa.en_i = 1'b0; ifa.req_i = '0; ifa.dwell_i = '0;
    ifb.en_i = 1'b0; ifb.req_i = '0; ifb.dwell_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sel",   32'(ifa.sel_o),       0);
    chk("rst_grant", 32'(ifa.grant_o),     0);
    chk("rst_valid", 32'(ifa.valid_o),     0);
    chk("rst_busy",  32'(ifa.busy_o),      0);
    chk("rst_done",  32'(ifa.slot_done_o), 0);
    chk("rst_data",  32'(ifa.data_o),      0);
    #1 rst_n = 1'b1;

    // Single channel 5, dwell 4, one guard cycle
    @(posedge clk); #1;
    push(5, 4);
    ifa.en_i = 1'b1; ifa.req_i = 8'h20; ifa.dwell_i = 8'd4;
    @(negedge clk);
    chk("single_idle_busy", 32'(ifa.busy_o), 0);
    @(negedge clk);
    chk("single_arb_busy",  32'(ifa.busy_o),  1);
    chk("single_arb_valid", 32'(ifa.valid_o), 0);
    @(posedge clk); #1;
    ifa.en_i = 1'b0; ifa.req_i = '0;
    @(negedge clk);
    chk("single_settle_sel",   32'(ifa.sel_o),   5);
    chk("single_settle_grant", 32'(ifa.grant_o), 32'h20);
    chk("single_settle_valid", 32'(ifa.valid_o), 0);
    @(negedge clk);
    chk("single_dwell_valid",  32'(ifa.valid_o), 1);
    wait_done("single");
    @(negedge clk);
    chk("single_end_busy",  32'(ifa.busy_o),  0);
    chk("single_end_grant", 32'(ifa.grant_o), 0);
    chk("single_end_sel",   32'(ifa.sel_o),   5);

    // Zero dwell, zero guard on the second instance
    @(posedge clk); #1;
    ifb.en_i = 1'b1; ifb.req_i = 8'h08; ifb.dwell_i = 8'd0;
    @(negedge clk);
    chk("z_idle_busy", 32'(ifb.busy_o), 0);
    @(negedge clk);
    chk("z_arb_busy",  32'(ifb.busy_o),  1);
    chk("z_arb_valid", 32'(ifb.valid_o), 0);
    @(posedge clk); #1;
    ifb.en_i = 1'b0; ifb.req_i = '0;
    @(negedge clk);
    chk("z_dwell_valid", 32'(ifb.valid_o),     1);
    chk("z_dwell_sel",   32'(ifb.sel_o),       3);
    chk("z_dwell_grant", 32'(ifb.grant_o),     32'h08);
    chk("z_dwell_done",  32'(ifb.slot_done_o), 1);
    chk("z_dwell_data",  32'(ifb.data_o),      32'(ifb.data_i));
    @(negedge clk);
    chk("z_end_valid", 32'(ifb.valid_o), 0);
    chk("z_end_busy",  32'(ifb.busy_o),  0);
    chk("z_end_grant", 32'(ifb.grant_o), 0);

    // Wrap and skip: pointer at 6, requests 0 and 2
    @(posedge clk); #1;
    push(0, 3); push(2, 3);
    ifa.en_i = 1'b1; ifa.req_i = 8'h05; ifa.dwell_i = 8'd3;
    wait_done("wrap_first");
    @(posedge clk); @(posedge clk); #1;
    ifa.en_i = 1'b0; ifa.req_i = '0;
    wait_done("wrap_second");
    @(negedge clk);
    chk("wrap_end_busy", 32'(ifa.busy_o), 0);

    // Mid-slot drop of enable and request: slot still runs to completion
    @(posedge clk); #1;
    push(4, 5);
    ifa.en_i = 1'b1; ifa.req_i = 8'h10; ifa.dwell_i = 8'd5;
    wait_sig("mid_valid", 1'b1);
    ifa.en_i = 1'b0; ifa.req_i = '0;
    wait_done("mid");
    @(negedge clk);
    chk("mid_end_busy",  32'(ifa.busy_o),  0);
    chk("mid_end_grant", 32'(ifa.grant_o), 0);
    chk("mid_end_sel",   32'(ifa.sel_o),   4);

    // Reset in the middle of a dwell on channel 7
    @(posedge clk); #1;
    ifa.en_i = 1'b1; ifa.req_i = 8'h80; ifa.dwell_i = 8'd8;
    wait_sig("rst_mid_valid", 1'b1);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_sel", 32'(ifa.sel_o), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_sel",   32'(ifa.sel_o),       0);
    chk("mrst_grant", 32'(ifa.grant_o),     0);
    chk("mrst_valid", 32'(ifa.valid_o),     0);
    chk("mrst_busy",  32'(ifa.busy_o),      0);
    chk("mrst_done",  32'(ifa.slot_done_o), 0);
    chk("mrst_data",  32'(ifa.data_o),      0);
    @(negedge clk);
    ifa.req_i = 8'h01; ifa.dwell_i = 8'd3;
    push(0, 3);
    #1 rst_n = 1'b1;
    wait_sig("post_rst_busy", 1'b0);
    @(posedge clk); #1;
    ifa.en_i = 1'b0; ifa.req_i = '0;
    wait_done("post_rst");

    // Round robin with every channel requesting, starting from pointer 1
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) push((1 + i) % 8, 2);
    ifa.en_i = 1'b1; ifa.req_i = 8'hFF; ifa.dwell_i = 8'd2;
    for (int i = 0; i < 8; i++) wait_done("rr");
    @(posedge clk); @(posedge clk); #1;
    ifa.en_i = 1'b0; ifa.req_i = '0;
    wait_done("rr_last");
    @(negedge clk);
    chk("rr_end_busy", 32'(ifa.busy_o), 0);
    chk("rr_queue_empty", 32'(q.size()), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
